// File: rtl/ram16k_arbiter_if.sv
// Bus bundle between the two requesting ports, the arbiter and the RAM16K.
// slave = arbiter view, master = requester/RAM view.
interface ram16k_arbiter_if;
  logic        a_req;
  logic [14:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_we;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        a_err;

  logic        b_req;
  logic [14:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_we;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        b_err;

  logic [14:0] ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  modport slave (
    input  a_req, a_addr, a_wdata, a_we,
    output a_ack, a_rdata, a_err,
    input  b_req, b_addr, b_wdata, b_we,
    output b_ack, b_rdata, b_err,
    output ram_address, ram_in, ram_load,
    input  ram_out
  );

  modport master (
    output a_req, a_addr, a_wdata, a_we,
    input  a_ack, a_rdata, a_err,
    output b_req, b_addr, b_wdata, b_we,
    input  b_ack, b_rdata, b_err,
    input  ram_address, ram_in, ram_load,
    output ram_out
  );
endinterface

// File: rtl/ram16k_arbiter.sv
// Two-port arbiter in front of a single-ported RAM16K; one access per three cycles.
// state  | meaning
// IDLE   | waiting for a request; grant and latch the winning port
// ACCESS | latched address/data on the RAM, write strobe if in range
// DONE   | ack (and err) to the granted port, read data returned
module ram16k_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  ram16k_arbiter_if.slave   bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        grant_a, grant_b;
  logic        sel_b;
  logic        last_b;
  logic        oor;
  logic [15:0] rd_val;
  logic [15:0] a_rdata_q, b_rdata_q;

  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          state_nxt = ACCESS;
          // B wins alone, or on a tie when round-robin says A went last
          if (bus.b_req && (!bus.a_req || (RR_ENABLE && !last_b)))
            grant_b = 1'b1;
          else
            grant_a = 1'b1;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      sel_b           <= 1'b0;
      last_b          <= 1'b1;
      bus.ram_address <= '0;
      bus.ram_in      <= '0;
      bus.ram_load    <= 1'b0;
      a_rdata_q       <= '0;
      b_rdata_q       <= '0;
    end else begin
      state        <= state_nxt;
      bus.ram_load <= (grant_a && bus.a_we && !bus.a_addr[14]) ||
                      (grant_b && bus.b_we && !bus.b_addr[14]);
      if (grant_a || grant_b) begin
        sel_b           <= grant_b;
        last_b          <= grant_b;
        bus.ram_address <= grant_b ? bus.b_addr  : bus.a_addr;
        bus.ram_in      <= grant_b ? bus.b_wdata : bus.a_wdata;
      end
      if (bus.a_ack) a_rdata_q <= rd_val;
      if (bus.b_ack) b_rdata_q <= rd_val;
    end
  end

  // ram_address holds the latched address through DONE, so it still qualifies range
  assign oor         = bus.ram_address[14];
  assign rd_val      = oor ? 16'h0000 : bus.ram_out;

  assign bus.a_ack   = (state == DONE) && !sel_b;
  assign bus.b_ack   = (state == DONE) &&  sel_b;
  assign bus.a_err   = bus.a_ack && oor;
  assign bus.b_err   = bus.b_ack && oor;
  assign bus.a_rdata = bus.a_ack ? rd_val : a_rdata_q;
  assign bus.b_rdata = bus.b_ack ? rd_val : b_rdata_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Directed bench for ram16k_arbiter: round-robin DUT with a RAM16K model,
// plus a fixed-priority DUT used only for the priority check.
module tb_ram16k_arbiter;
  logic clk;
  logic rst_n;
  logic busy0, busy1;

  ram16k_arbiter_if bus0();
  ram16k_arbiter_if bus1();

  ram16k_arbiter #(.RR_ENABLE(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0));
  ram16k_arbiter #(.RR_ENABLE(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem0 [16384];
  always @(posedge clk) if (bus0.ram_load) mem0[bus0.ram_address[13:0]] <= bus0.ram_in;
  assign bus0.ram_out = mem0[bus0.ram_address[13:0]];
  assign bus1.ram_out = 16'h0000;

  int n_pass, n_total;
  bit oor_load_seen;
  bit dual_ack_seen;

  always @(posedge clk) begin
    if (bus0.ram_load && bus0.ram_address[14]) oor_load_seen = 1'b1;
    if ((bus0.a_ack && bus0.b_ack) || (bus1.a_ack && bus1.b_ack)) dual_ack_seen = 1'b1;
  end

  task automatic idle_inputs();
    bus0.a_req = 0; bus0.a_addr = '0; bus0.a_wdata = '0; bus0.a_we = 0;
    bus0.b_req = 0; bus0.b_addr = '0; bus0.b_wdata = '0; bus0.b_we = 0;
    bus1.a_req = 0; bus1.a_addr = '0; bus1.a_wdata = '0; bus1.a_we = 0;
    bus1.b_req = 0; bus1.b_addr = '0; bus1.b_wdata = '0; bus1.b_we = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Starts and ends at a negedge; lat = rising edges from req raised to ack seen
  task automatic access(input bit port_b, input bit we, input logic [14:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output logic er, output int lat);
    int guard;
    guard = 0;
    while (busy0 && guard < 10) begin @(negedge clk); guard++; end
    if (port_b) begin
      bus0.b_req = 1; bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wd;
    end else begin
      bus0.a_req = 1; bus0.a_we = we; bus0.a_addr = addr; bus0.a_wdata = wd;
    end
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!(port_b ? bus0.b_ack : bus0.a_ack) && lat < 10);
    rd = port_b ? bus0.b_rdata : bus0.a_rdata;
    er = port_b ? bus0.b_err   : bus0.a_err;
    bus0.a_req = 0; bus0.b_req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #12;
    n_total++;
    if ({bus0.a_ack, bus0.a_err, bus0.b_ack, bus0.b_err, bus0.ram_load, busy0} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus0.a_ack, bus0.a_err, bus0.b_ack, bus0.b_err, bus0.ram_load, busy0});
    else n_pass++;
    n_total++;
    if ({bus0.a_rdata, bus0.b_rdata} !== 32'h0)
      $display("FAIL reset_rdata: got a=%h b=%h want 0", bus0.a_rdata, bus0.b_rdata);
    else n_pass++;
    n_total++;
    if ({bus0.ram_address, bus0.ram_in} !== 31'h0)
      $display("FAIL reset_ram: got addr=%h in=%h want 0", bus0.ram_address, bus0.ram_in);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] rd; logic er; int lat;
    access(0, 1, 15'h0001, 16'h1111, rd, er, lat);
    n_total++;
    if (lat !== 2 || er !== 1'b0) $display("FAIL basic_write: lat=%0d err=%b want lat=2 err=0", lat, er);
    else n_pass++;
    access(0, 0, 15'h0001, 16'h0000, rd, er, lat);
    n_total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 16'h1111)
      $display("FAIL basic_read: lat=%0d err=%b rdata=%h want 2/0/1111", lat, er, rd);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus0.a_rdata !== 16'h1111 || bus0.a_ack !== 1'b0)
      $display("FAIL basic_hold: rdata=%h ack=%b want 1111/0", bus0.a_rdata, bus0.a_ack);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int cyc[4]; bit prt[4]; int n;
    apply_reset();
    n = 0;
    bus0.a_req = 1; bus0.a_we = 1; bus0.a_addr = 15'h0010; bus0.a_wdata = 16'haaaa;
    bus0.b_req = 1; bus0.b_we = 1; bus0.b_addr = 15'h0011; bus0.b_wdata = 16'hbbbb;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if ((bus0.a_ack || bus0.b_ack) && n < 4) begin
        cyc[n] = c; prt[n] = bus0.b_ack; n++;
      end
    end
    bus0.a_req = 0; bus0.b_req = 0;
    n_total++;
    if (n !== 4) $display("FAIL rr_count: got %0d acks want 4", n);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        n_total++;
        if (cyc[k] !== 2 + 3*k || prt[k] !== k[0])
          $display("FAIL rr_ack%0d: cycle=%0d port_b=%b want cycle=%0d port_b=%b",
                   k, cyc[k], prt[k], 2 + 3*k, k[0]);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_total++;
    if (mem0[16'h0010] !== 16'haaaa || mem0[16'h0011] !== 16'hbbbb)
      $display("FAIL rr_data: got %h %h want aaaa bbbb", mem0[16'h0010], mem0[16'h0011]);
    else n_pass++;
  endtask

  task automatic test_fixed_priority();
    int na, nb;
    na = 0; nb = 0;
    bus1.a_req = 1; bus1.a_addr = 15'h0020;
    bus1.b_req = 1; bus1.b_addr = 15'h0021;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (bus1.a_ack) na++;
      if (bus1.b_ack) nb++;
    end
    bus1.a_req = 0; bus1.b_req = 0;
    n_total++;
    if (na !== 10 || nb !== 0) $display("FAIL fixed_prio: a_acks=%0d b_acks=%0d want 10/0", na, nb);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic er; int lat;
    access(1, 1, 15'h0000, 16'h1234, rd, er, lat);
    oor_load_seen = 0;
    access(1, 1, 15'h4000, 16'hffff, rd, er, lat);
    n_total++;
    if (er !== 1'b1 || lat !== 2) $display("FAIL oor_write: err=%b lat=%0d want 1/2", er, lat);
    else n_pass++;
    access(1, 0, 15'h4000, 16'h0000, rd, er, lat);
    n_total++;
    if (er !== 1'b1 || rd !== 16'h0000) $display("FAIL oor_read: err=%b rdata=%h want 1/0000", er, rd);
    else n_pass++;
    n_total++;
    if (oor_load_seen !== 1'b0) $display("FAIL oor_load: ram_load seen=%b want 0", oor_load_seen);
    else n_pass++;
    access(1, 0, 15'h0000, 16'h0000, rd, er, lat);
    n_total++;
    if (rd !== 16'h1234 || er !== 1'b0) $display("FAIL oor_word0: rdata=%h err=%b want 1234/0", rd, er);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd; logic er; int lat; bit ack_seen;
    access(0, 1, 15'h0005, 16'h00a5, rd, er, lat);
    @(negedge clk);
    bus0.a_req = 1; bus0.a_we = 1; bus0.a_addr = 15'h0005; bus0.a_wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus0.ram_load !== 1'b1 || busy0 !== 1'b1)
      $display("FAIL abort_access: ram_load=%b busy=%b want 1/1", bus0.ram_load, busy0);
    else n_pass++;
    rst_n = 0;
    #1;
    n_total++;
    if (bus0.ram_load !== 1'b0 || busy0 !== 1'b0 || bus0.a_ack !== 1'b0)
      $display("FAIL abort_reset: ram_load=%b busy=%b ack=%b want 0/0/0", bus0.ram_load, busy0, bus0.a_ack);
    else n_pass++;
    @(negedge clk);
    bus0.a_req = 0;
    rst_n = 1;
    ack_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus0.a_ack) ack_seen = 1;
    end
    n_total++;
    if (ack_seen !== 1'b0) $display("FAIL abort_noack: ack seen=%b want 0", ack_seen);
    else n_pass++;
    access(0, 0, 15'h0005, 16'h0000, rd, er, lat);
    n_total++;
    if (rd !== 16'h00a5) $display("FAIL abort_readback: rdata=%h want 00a5", rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, v; logic er; int lat; int errs;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      v = 16'(i * 16'h1111);
      access(i[0], 1, 15'(i), v, rd, er, lat);
      if (er) errs++;
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) begin
        v = 16'(i * 16'h1111);
        access(p[0], 0, 15'(i), 16'h0000, rd, er, lat);
        if (er) errs++;
        n_total++;
        if (rd !== v || lat !== 2)
          $display("FAIL b2b_read port%0d addr%0d: rdata=%h lat=%0d want %h/2", p, i, rd, lat, v);
        else n_pass++;
      end
    end
    n_total++;
    if (errs !== 0) $display("FAIL b2b_err: err pulses=%0d want 0", errs);
    else n_pass++;
    n_total++;
    if (dual_ack_seen !== 1'b0) $display("FAIL one_ack: dual ack seen=%b want 0", dual_ack_seen);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    oor_load_seen = 0;
    dual_ack_seen = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_fixed_priority();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
